adc_par_ctrl: RTL

Parametrised controller for AD7606-class parallel simultaneous-sampling ADCs. It is the successor to the fixed 8-channel driver and takes its place in front of the voltage-conversion and UART stages. It adds a programmable sample rate, continuous and single-shot modes, and a configurable channel count. Samples leave through a channel-tagged valid/ready stream backed by a FIFO, with sticky error reporting.

---
 rtl/adc_par_pkg.sv | 26 ++
 rtl/adc_sync_fifo.sv | 47 ++++
 rtl/adc_par_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_par_pkg.sv
// Shared types and constants for the AD7606-class parallel ADC controller.
// Holds the FSM state encoding, channel index width and FIFO entry layout helpers.
package adc_par_pkg;

    localparam int CH_W = 3;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_CONV,
        ST_WAIT_H,
        ST_WAIT_L,
        ST_READ,
        ST_DONE
    } state_t;

    // A FIFO entry is {ch, data}: channel index in the top CH_W bits, sample below.
    function automatic int entry_w(input int dw);
        return CH_W + dw;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; o_data shows the head entry whenever !o_empty.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module adc_sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = ((r_wr_ptr - r_rd_ptr) == PW'(DEPTH));
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/adc_par_ctrl.sv
// AD7606-class parallel ADC controller: rate generator, conversion/read FSM, tagged FWFT sample stream.
// Build option: define ADC_BUSY_TIMEOUT_EN to abort and re-reset the ADC when ad_busy never toggles.
module adc_par_ctrl
    import adc_par_pkg::*;
#(
    parameter int CH_NUM      = 8,
    parameter int DW          = 16,
    parameter int SAMPLE_DIV  = 2500,
    parameter int RESET_CYC   = 10,
    parameter int CONV_LOW    = 2,
    parameter int RD_LOW      = 2,
    parameter int RD_HIGH     = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cont_en,
    input  logic            trig,
    input  logic [2:0]      os_sel,
    input  logic            err_clr,
    input  logic [DW-1:0]   ad_data,
    input  logic            ad_busy,
    input  logic            first_data,
    output logic [2:0]      ad_os,
    output logic            ad_cs,
    output logic            ad_rd,
    output logic            ad_reset,
    output logic            ad_convstab,
    output logic [DW-1:0]   m_data,
    output logic [CH_W-1:0] m_ch,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            frame_done,
    output logic            ovf_err,
    output logic            seq_err,
    output logic            miss_err,
    output logic            timeout_err
);
    localparam int EW      = entry_w(DW);
    localparam int CNT_MAX = max2(max2(RESET_CYC, CONV_LOW), max2(RD_LOW + RD_HIGH, TIMEOUT_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RATE_W  = $clog2(SAMPLE_DIV);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CH_W-1:0]   r_ch, w_ch_nxt;
    logic [RATE_W-1:0] r_rate;
    logic [2:0]        r_ad_os;
    logic              r_ovf_err, r_seq_err, r_miss_err;
    logic              w_tick, w_start, w_push, w_pop, w_full, w_empty;
    logic [EW-1:0]     w_wr_data, w_rd_data;
`ifdef ADC_BUSY_TIMEOUT_EN
    logic              w_timeout;
    logic              r_timeout_err;
`endif

    assign w_tick  = cont_en && (r_rate == RATE_W'(SAMPLE_DIV - 1));
    assign w_start = w_tick || (trig && !cont_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_rate <= '0;
        else if (!cont_en || w_tick) r_rate <= '0;
        else                        r_rate <= r_rate + RATE_W'(1);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        w_push      = 1'b0;
`ifdef ADC_BUSY_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            ST_RST: begin
                if (r_cnt == CNT_W'(RESET_CYC - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_CONV;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CONV: begin
                if (r_cnt == CNT_W'(CONV_LOW - 1)) begin
                    w_state_nxt = ST_WAIT_H;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_H, ST_WAIT_L: begin
`ifdef ADC_BUSY_TIMEOUT_EN
                w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
                if (r_state == ST_WAIT_H && ad_busy) begin
                    w_state_nxt = ST_WAIT_L;
                end else if (r_state == ST_WAIT_L && !ad_busy) begin
                    w_state_nxt = ST_READ;
                    w_cnt_nxt   = '0;
                    w_ch_nxt    = '0;
                end
`ifdef ADC_BUSY_TIMEOUT_EN
                // The timeout window spans both wait states and overrides any busy transition.
                if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RST;
                    w_cnt_nxt   = '0;
                end
`endif
            end
            ST_READ: begin
                w_push = (r_cnt == CNT_W'(RD_LOW - 1));
                if (r_cnt == CNT_W'(RD_LOW + RD_HIGH - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_ch == CH_W'(CH_NUM - 1)) w_state_nxt = ST_DONE;
                    else                           w_ch_nxt    = r_ch + CH_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: begin
                w_state_nxt = ST_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_ad_os <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ch    <= w_ch_nxt;
            // Oversampling must not change while a conversion or readout is in flight.
            if (r_state == ST_RST || r_state == ST_IDLE) r_ad_os <= os_sel;
        end
    end

    assign ad_os       = r_ad_os;
    assign ad_reset    = (r_state == ST_RST);
    assign ad_convstab = (r_state != ST_CONV);
    assign ad_cs       = (r_state != ST_READ);
    assign ad_rd       = !((r_state == ST_READ) && (r_cnt < CNT_W'(RD_LOW)));
    assign frame_done  = (r_state == ST_DONE);

    assign w_wr_data = {r_ch, ad_data};
    assign w_pop     = !w_empty && m_ready;

    adc_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_wr_data),
        .i_pop   (w_pop),
        .o_data  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_valid = !w_empty;
    assign m_ch    = w_rd_data[EW-1 -: CH_W];
    assign m_data  = w_rd_data[DW-1:0];

    // Sticky flags: a set event in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_err  <= 1'b0;
            r_seq_err  <= 1'b0;
            r_miss_err <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop)                r_ovf_err <= 1'b1;
            else if (err_clr)                              r_ovf_err <= 1'b0;
            if (w_push && (first_data != (r_ch == '0)))    r_seq_err <= 1'b1;
            else if (err_clr)                              r_seq_err <= 1'b0;
            if (w_tick && (r_state != ST_IDLE))            r_miss_err <= 1'b1;
            else if (err_clr)                              r_miss_err <= 1'b0;
        end
    end

    assign ovf_err  = r_ovf_err;
    assign seq_err  = r_seq_err;
    assign miss_err = r_miss_err;

`ifdef ADC_BUSY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_timeout_err <= 1'b0;
        else if (w_timeout) r_timeout_err <= 1'b1;
        else if (err_clr)   r_timeout_err <= 1'b0;
    end
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
